// File: rtl/rot_pkg.sv
// Shared constants, state encoding and quadrature phase table for the rotary emulator.
package rot_pkg;

    localparam int unsigned PHASE_CYC_DEF = 64;
    localparam int unsigned GAP_CYC_DEF   = 512;
    localparam int unsigned CNT_W_DEF     = 8;
    localparam int unsigned TMR_W         = 16;

    localparam logic [1:0] ROT_IDLE_AB = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PH1,
        ST_PH2,
        ST_PH3,
        ST_PH4,
        ST_GAP,
        ST_PUSH
    } rot_state_e;

    // {A,B} levels for a phase state; inc=1 means B leads.
    function automatic logic [1:0] phase_ab(input rot_state_e st, input logic inc);
        logic [1:0] ab;
        ab = ROT_IDLE_AB;
        case (st)
            ST_PH1:  ab = inc ? 2'b10 : 2'b01;
            ST_PH2:  ab = 2'b00;
            ST_PH3:  ab = inc ? 2'b01 : 2'b10;
            default: ab = ROT_IDLE_AB;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/rot_phase_timer.sv
// Loadable down-counter; tc_c is high while the count sits at zero.
module rot_phase_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/rot_quad_gen.sv
// Quadrature rotary-encoder emulator: turns detent commands and push requests
// into Rot_A/Rot_B/Rot_C waveforms paced for the Rotary decoder.
module rot_quad_gen
    import rot_pkg::*;
#(
    parameter int unsigned PHASE_CYC = PHASE_CYC_DEF,
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             Fg_clk,
    input  logic             Reset,
    input  logic             Cmd_valid,
    output logic             Cmd_ready,
    input  logic             Cmd_dir,
    input  logic [CNT_W-1:0] Cmd_cnt,
    input  logic             Push_req,
    input  logic             Abort,
    output logic             Rot_A,
    output logic             Rot_B,
    output logic             Rot_C,
    output logic             Busy,
    output logic             Done
);

    localparam logic [TMR_W-1:0] PHASE_LD = TMR_W'(PHASE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

    rot_state_e       state;
    logic             dir_q;
    logic             abort_q;
    logic [CNT_W-1:0] rem_q;

    logic             acc_cmd_c;
    logic             acc_push_c;
    logic             abort_any_c;
    logic             tmr_load_c;
    logic [TMR_W-1:0] tmr_val_c;
    logic             tmr_tc_c;

    assign acc_cmd_c   = Cmd_valid & Cmd_ready;
    assign acc_push_c  = Push_req & Cmd_ready & ~Cmd_valid;
    assign abort_any_c = abort_q | Abort;

    // One timer serves every state; it is reloaded on each state entry.
    rot_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (Fg_clk),
        .rst      (Reset),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .tc_c     (tmr_tc_c)
    );

    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        case (state)
            ST_IDLE: begin
                if (acc_cmd_c && (Cmd_cnt != '0)) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = PHASE_LD;
                end else if (acc_push_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = '0;
                end
            end
            ST_PH1, ST_PH2, ST_PH3, ST_GAP: begin
                tmr_load_c = tmr_tc_c;
                tmr_val_c  = PHASE_LD;
            end
            ST_PH4, ST_PUSH: begin
                tmr_load_c = tmr_tc_c;
                tmr_val_c  = GAP_LD;
            end
            default: begin
                tmr_load_c = 1'b0;
                tmr_val_c  = '0;
            end
        endcase
    end

    always_ff @(posedge Fg_clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            dir_q     <= 1'b0;
            abort_q   <= 1'b0;
            rem_q     <= '0;
            Rot_A     <= 1'b1;
            Rot_B     <= 1'b1;
            Rot_C     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Cmd_ready <= 1'b1;
        end else begin
            Done  <= 1'b0;
            Rot_C <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (acc_cmd_c) begin
                        dir_q <= Cmd_dir;
                        if (Cmd_cnt == '0) begin
                            Done <= 1'b1;
                        end else begin
                            rem_q          <= Cmd_cnt;
                            state          <= ST_PH1;
                            {Rot_A, Rot_B} <= phase_ab(ST_PH1, Cmd_dir);
                            Busy           <= 1'b1;
                            Cmd_ready      <= 1'b0;
                        end
                    end else if (acc_push_c) begin
                        rem_q     <= '0;
                        state     <= ST_PUSH;
                        Rot_C     <= 1'b1;
                        Busy      <= 1'b1;
                        Cmd_ready <= 1'b0;
                    end
                end
                ST_PH1: begin
                    abort_q <= abort_any_c;
                    if (tmr_tc_c) begin
                        state          <= ST_PH2;
                        {Rot_A, Rot_B} <= phase_ab(ST_PH2, dir_q);
                    end
                end
                ST_PH2: begin
                    abort_q <= abort_any_c;
                    if (tmr_tc_c) begin
                        state          <= ST_PH3;
                        {Rot_A, Rot_B} <= phase_ab(ST_PH3, dir_q);
                    end
                end
                ST_PH3: begin
                    abort_q <= abort_any_c;
                    if (tmr_tc_c) begin
                        state          <= ST_PH4;
                        {Rot_A, Rot_B} <= phase_ab(ST_PH4, dir_q);
                    end
                end
                ST_PH4: begin
                    abort_q <= abort_any_c;
                    if (tmr_tc_c) begin
                        state          <= ST_GAP;
                        {Rot_A, Rot_B} <= ROT_IDLE_AB;
                        if (rem_q != '0) begin
                            rem_q <= rem_q - CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    abort_q <= abort_any_c;
                    if (tmr_tc_c) begin
                        if ((rem_q != '0) && !abort_any_c) begin
                            state          <= ST_PH1;
                            {Rot_A, Rot_B} <= phase_ab(ST_PH1, dir_q);
                        end else begin
                            state     <= ST_IDLE;
                            abort_q   <= 1'b0;
                            rem_q     <= '0;
                            Busy      <= 1'b0;
                            Cmd_ready <= 1'b1;
                            Done      <= 1'b1;
                        end
                    end
                end
                ST_PUSH: begin
                    if (tmr_tc_c) begin
                        state <= ST_GAP;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rot_quad_gen.sv
// Self-checking bench for rot_quad_gen: table of directed transactions, reset
// corner case and randomized traffic checked against a cycle-offset model.
module tb_rot_quad_gen;

    localparam int PH  = 64;
    localparam int GP  = 512;
    localparam int DET = 4 * PH + GP;

    logic       clk;
    logic       Reset;
    logic       Cmd_valid;
    logic       Cmd_ready;
    logic       Cmd_dir;
    logic [7:0] Cmd_cnt;
    logic       Push_req;
    logic       Abort;
    logic       Rot_A, Rot_B, Rot_C, Busy, Done;

    int total;
    int bad;

    rot_quad_gen #(.PHASE_CYC(PH), .GAP_CYC(GP), .CNT_W(8)) dut (
        .Fg_clk    (clk),
        .Reset     (Reset),
        .Cmd_valid (Cmd_valid),
        .Cmd_ready (Cmd_ready),
        .Cmd_dir   (Cmd_dir),
        .Cmd_cnt   (Cmd_cnt),
        .Push_req  (Push_req),
        .Abort     (Abort),
        .Rot_A     (Rot_A),
        .Rot_B     (Rot_B),
        .Rot_C     (Rot_C),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = command, 1 = push, 2 = command and push together
    typedef struct {
        int   kind;
        logic dir;
        int   cnt;
        int   abort_at;
        int   exp_done;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {Rot_A, Rot_B, Rot_C, Busy, Cmd_ready, Done};
    endfunction

    function automatic int eff_detents(input int kind, input int cnt, input int abort_at);
        int n;
        if (kind == 1) return 0;
        n = cnt;
        if (abort_at >= 0 && (abort_at / DET + 1) < n) n = abort_at / DET + 1;
        return n;
    endfunction

    // Expected {A,B,C,Busy,Ready,Done} at o cycles after the accepting edge.
    function automatic logic [5:0] model(input int kind, input logic dir, input int n, input int o);
        logic a, b, c, busy, done, lead_low, lag_low;
        int   last, w, p;
        a = 1'b1; b = 1'b1; c = 1'b0;
        if (kind == 1) begin
            last = GP + 1;
            c    = (o == 0);
        end else begin
            last = n * DET;
            if (o < last) begin
                w = o % DET;
                if (w < 4 * PH) begin
                    p        = w / PH;
                    lead_low = (p < 2);
                    lag_low  = (p == 1) || (p == 2);
                    if (dir) begin
                        b = ~lead_low; a = ~lag_low;
                    end else begin
                        a = ~lead_low; b = ~lag_low;
                    end
                end
            end
        end
        busy = (o < last);
        done = (o == last);
        return {a, b, c, busy, ~busy, done};
    endfunction

    task automatic do_txn(input int kind, input logic dir, input int cnt, input int abort_at,
                          input bit noise, input string tag,
                          output int done_off, output int c_hi, output int model_last);
        int         n_eff, wait_n, bad_cyc, first_o;
        logic [5:0] got, exp, first_got, first_exp;
        wait_n = 0;
        while (Cmd_ready !== 1'b1 && wait_n < 3000) begin
            tick();
            wait_n++;
        end
        if (Cmd_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s ready_timeout got=%b want=1", tag, Cmd_ready);
        end
        Cmd_valid = (kind != 1);
        Push_req  = (kind != 0);
        Cmd_dir   = dir;
        Cmd_cnt   = 8'(cnt);
        tick();
        Cmd_valid = 1'b0;
        Push_req  = 1'b0;
        n_eff      = eff_detents(kind, cnt, abort_at);
        model_last = (kind == 1) ? GP + 1 : n_eff * DET;
        done_off   = -1;
        c_hi       = 0;
        bad_cyc    = 0;
        first_o    = 0;
        first_got  = '0;
        first_exp  = '0;
        for (int o = 0; o <= model_last + 2; o++) begin
            got = outs();
            exp = model(kind, dir, n_eff, o);
            if (got !== exp) begin
                if (bad_cyc == 0) begin
                    first_o = o; first_got = got; first_exp = exp;
                end
                bad_cyc++;
            end
            if (Done === 1'b1 && done_off < 0) done_off = o;
            if (Rot_C === 1'b1) c_hi++;
            Abort = (o == abort_at);
            if (noise && o + 2 < model_last) begin
                Cmd_valid = 1'($urandom);
                Push_req  = 1'($urandom);
                Cmd_dir   = 1'($urandom);
                Cmd_cnt   = 8'($urandom);
            end else begin
                Cmd_valid = 1'b0;
                Push_req  = 1'b0;
            end
            tick();
        end
        Abort = 1'b0;
        total++;
        if (bad_cyc != 0) begin
            bad++;
            $display("FAIL %s wave at offset %0d got ABC/busy/rdy/done=%b want=%b (%0d bad cycles)",
                     tag, first_o, first_got, first_exp, bad_cyc);
        end
    endtask

    initial begin
        vec_t       vecs[8];
        int         done_off, c_hi, mlast, kind, cnt, ab, quiet_bad;
        logic       dir;
        logic [5:0] got;

        total = 0;
        bad   = 0;
        Reset = 1'b1;
        Cmd_valid = 1'b0; Cmd_dir = 1'b0; Cmd_cnt = '0; Push_req = 1'b0; Abort = 1'b0;

        vecs[0] = '{kind: 0, dir: 1'b1, cnt: 3,  abort_at: -1,                 exp_done: 2304};
        vecs[1] = '{kind: 0, dir: 1'b0, cnt: 1,  abort_at: -1,                 exp_done: 768};
        vecs[2] = '{kind: 0, dir: 1'b1, cnt: 10, abort_at: DET + 2 * PH + 5,   exp_done: 1536};
        vecs[3] = '{kind: 1, dir: 1'b0, cnt: 0,  abort_at: -1,                 exp_done: 513};
        vecs[4] = '{kind: 2, dir: 1'b1, cnt: 0,  abort_at: -1,                 exp_done: 0};
        vecs[5] = '{kind: 0, dir: 1'b0, cnt: 0,  abort_at: -1,                 exp_done: 0};
        vecs[6] = '{kind: 0, dir: 1'b1, cnt: 2,  abort_at: DET + 4 * PH - 1,   exp_done: 1536};
        vecs[7] = '{kind: 0, dir: 1'b0, cnt: 2,  abort_at: DET - 1,            exp_done: 768};

        tick();
        tick();
        got = outs();
        total++;
        if (got !== 6'b110010) begin
            bad++;
            $display("FAIL reset_state got=%b want=110010", got);
        end
        @(negedge clk);
        Reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_txn(vecs[i].kind, vecs[i].dir, vecs[i].cnt, vecs[i].abort_at, 1'b0,
                   $sformatf("vec%0d", i), done_off, c_hi, mlast);
            total++;
            if (done_off != vecs[i].exp_done) begin
                bad++;
                $display("FAIL vec%0d done_offset got=%0d want=%0d", i, done_off, vecs[i].exp_done);
            end
            total++;
            if (c_hi != (vecs[i].kind == 1 ? 1 : 0)) begin
                bad++;
                $display("FAIL vec%0d rot_c_cycles got=%0d want=%0d", i, c_hi,
                         (vecs[i].kind == 1 ? 1 : 0));
            end
        end

        // Asynchronous reset in the middle of PH2 of an increase detent.
        Cmd_valid = 1'b1; Cmd_dir = 1'b1; Cmd_cnt = 8'd3;
        tick();
        Cmd_valid = 1'b0;
        repeat (PH + 10) tick();
        got = outs();
        total++;
        if (got[5:4] !== 2'b00) begin
            bad++;
            $display("FAIL pre_reset_ph2 got AB=%b want=00", got[5:4]);
        end
        #3;
        Reset = 1'b1;
        #1;
        got = outs();
        total++;
        if (got !== 6'b110010) begin
            bad++;
            $display("FAIL async_reset got=%b want=110010", got);
        end
        @(negedge clk);
        Reset = 1'b0;
        quiet_bad = 0;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (outs() !== 6'b110010) quiet_bad++;
        end
        total++;
        if (quiet_bad != 0) begin
            bad++;
            $display("FAIL post_reset_quiet got %0d non-idle cycles want 0", quiet_bad);
        end

        // Randomized traffic with input noise while busy.
        for (int r = 0; r < 14; r++) begin
            kind = $urandom_range(0, 9);
            kind = (kind < 7) ? 0 : (kind < 9 ? 1 : 2);
            cnt  = $urandom_range(0, 3);
            dir  = 1'($urandom);
            ab   = -1;
            if (kind != 1 && cnt > 0 && $urandom_range(0, 2) == 0)
                ab = $urandom_range(0, cnt * DET - 1);
            do_txn(kind, dir, cnt, ab, 1'b1, $sformatf("rnd%0d", r), done_off, c_hi, mlast);
            total++;
            if (done_off != mlast) begin
                bad++;
                $display("FAIL rnd%0d done_offset got=%0d want=%0d", r, done_off, mlast);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
